// File: rtl/mult_scaled.sv
// Pipelined signed multiplier with programmable rounding shift and
// symmetric saturation to OUTBITS, plus valid strobe and saturation status.
//
// Ports:
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous active-high reset
//   a_i, b_i     signed operands (INBITS1, INBITS2 wide)
//   valid_i      operands and shift_i are valid this cycle
//   shift_i      arithmetic right-shift amount, clamped to PW-1
//   clr_i        clears sticky flag and counter
//   result_o     scaled, rounded, saturated product (held between valids)
//   valid_o      result_o updated this cycle (3 cycles after valid_i)
//   sat_o        result_o of this valid_o was saturated
//   sat_sticky_o any saturation since reset/clear
//   sat_cnt_o    saturation event count
//
// Optional feature macro: MULT_SATCNT_EN builds the saturating event
// counter; without it sat_cnt_o is tied to 0.
//
// Status timing: a saturation event is the edge that raises valid_o with
// sat_o = 1. clr_i sampled on that same edge coincides with the event, and
// the set wins (sticky = 1, counter = 1).

module mult_scaled #(
  parameter int INBITS1     = 14,
  parameter int INBITS2     = 14,
  parameter int OUTBITS     = 14,
  parameter int SHIFTBITS   = 5,
  parameter int SATCNT_BITS = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic signed [INBITS1-1:0]     a_i,
  input  logic signed [INBITS2-1:0]     b_i,
  input  logic                          valid_i,
  input  logic        [SHIFTBITS-1:0]   shift_i,
  input  logic                          clr_i,
  output logic signed [OUTBITS-1:0]     result_o,
  output logic                          valid_o,
  output logic                          sat_o,
  output logic                          sat_sticky_o,
  output logic        [SATCNT_BITS-1:0] sat_cnt_o
);

  localparam int PW = INBITS1 + INBITS2;
  localparam int SW = $clog2(PW);

  // Output limits, sign-extended to the PW+1 rounding width
  localparam logic signed [PW:0] MAXV =
    {{(PW-OUTBITS+2){1'b0}}, {(OUTBITS-1){1'b1}}};
  localparam logic signed [PW:0] MINV =
    {{(PW-OUTBITS+2){1'b1}}, {(OUTBITS-1){1'b0}}};

  // Stage 1
  logic signed [INBITS1-1:0] a1;
  logic signed [INBITS2-1:0] b1;
  logic        [SW-1:0]      sh1;
  logic                      v1;
  logic        [SW-1:0]      sh_clamp;

  always_comb begin
    if (32'(shift_i) > PW-1) sh_clamp = SW'(PW-1);
    else                     sh_clamp = SW'(shift_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a1  <= '0;
      b1  <= '0;
      sh1 <= '0;
      v1  <= 1'b0;
    end else begin
      a1  <= a_i;
      b1  <= b_i;
      sh1 <= sh_clamp;
      v1  <= valid_i;
    end
  end

  // Stage 2: full-width product; shift travels alongside its sample
  logic signed [PW-1:0] p2;
  logic        [SW-1:0] sh2;
  logic                 v2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p2  <= '0;
      sh2 <= '0;
      v2  <= 1'b0;
    end else begin
      p2  <= PW'(a1) * PW'(b1);
      sh2 <= sh1;
      v2  <= v1;
    end
  end

  // Stage 3: round half up, shift, saturate
  logic signed [PW:0]        pext;
  logic signed [PW:0]        off;
  logic signed [PW:0]        sum;
  logic signed [PW:0]        shd;
  logic                      sat_hi;
  logic                      sat_lo;
  logic                      sat_n;
  logic signed [OUTBITS-1:0] res_n;
  logic                      ev;

  always_comb begin
    pext = {p2[PW-1], p2};
    off  = '0;
    if (sh2 != '0) off = (PW+1)'(1) << (sh2 - SW'(1));
    sum    = pext + off;
    shd    = sum >>> sh2;
    sat_hi = shd > MAXV;
    sat_lo = shd < MINV;
    sat_n  = sat_hi | sat_lo;
    res_n  = shd[OUTBITS-1:0];
    if (sat_hi) res_n = MAXV[OUTBITS-1:0];
    if (sat_lo) res_n = MINV[OUTBITS-1:0];
  end

  assign ev = v2 & sat_n;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_o     <= '0;
      valid_o      <= 1'b0;
      sat_o        <= 1'b0;
      sat_sticky_o <= 1'b0;
    end else begin
      valid_o      <= v2;
      sat_o        <= ev;
      if (v2) result_o <= res_n;
      sat_sticky_o <= ev | (sat_sticky_o & ~clr_i);
    end
  end

`ifdef MULT_SATCNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sat_cnt_o <= '0;
    end else if (clr_i) begin
      sat_cnt_o <= ev ? SATCNT_BITS'(1) : '0;
    end else if (ev && !(&sat_cnt_o)) begin
      sat_cnt_o <= sat_cnt_o + SATCNT_BITS'(1);
    end
  end
`else
  assign sat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mult_scaled.sv
// Self-checking bench for mult_scaled: fixed vectors, hand sequences and
// a randomized stream against a cycle-level arithmetic reference model.

module tb_mult_scaled;

  localparam int IA = 14;
  localparam int IB = 14;
  localparam int OB = 14;
  localparam int SB = 5;
  localparam int CB = 16;
  localparam int PW = IA + IB;
  localparam longint OMAX = (longint'(1) << (OB-1)) - 1;
  localparam longint OMIN = -(longint'(1) << (OB-1));

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [IA-1:0] a = '0;
  logic signed [IB-1:0] b = '0;
  logic                 vin = 1'b0;
  logic        [SB-1:0] sh = '0;
  logic                 clr = 1'b0;
  logic signed [OB-1:0] res;
  logic                 vout;
  logic                 sat;
  logic                 sticky;
  logic        [CB-1:0] cnt;

  int total = 0;
  int bad   = 0;

  mult_scaled #(
    .INBITS1(IA), .INBITS2(IB), .OUTBITS(OB),
    .SHIFTBITS(SB), .SATCNT_BITS(CB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b),
    .valid_i(vin), .shift_i(sh), .clr_i(clr),
    .result_o(res), .valid_o(vout), .sat_o(sat),
    .sat_sticky_o(sticky), .sat_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit     v;
    longint a;
    longint b;
    int     s;
  } smp_t;

  typedef struct {
    longint a;
    longint b;
    int     s;
    longint r;
    bit     sat;
  } vec_t;

  // reference model state: two samples in flight plus output registers
  smp_t   s1, s2;
  bit     m_v, m_sat, m_sticky;
  longint m_res;
  longint m_cnt;
  bit     cnt_en;

  task automatic chk(string n, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", n, act, exp, $time);
    end
  endtask

  // floor((p + 2^(e-1)) / 2^e), then clamp to the output range
  function automatic void ref_calc(input longint x, input longint y,
                                   input int s, output longint r,
                                   output bit st);
    longint p, d, num, q;
    int e;
    p = x * y;
    e = (s > PW-1) ? PW-1 : s;
    if (e == 0) begin
      q = p;
    end else begin
      d   = longint'(1) << e;
      num = p + d / 2;
      q   = num / d;
      if ((num % d != 0) && (num < 0)) q = q - 1;
    end
    st = 1'b1;
    if (q > OMAX)      r = OMAX;
    else if (q < OMIN) r = OMIN;
    else begin
      r  = q;
      st = 1'b0;
    end
  endfunction

  task automatic model_reset();
    s1 = '{0, 0, 0, 0};
    s2 = '{0, 0, 0, 0};
    m_v = 0; m_sat = 0; m_sticky = 0;
    m_res = 0; m_cnt = 0;
  endtask

  // one clock: advance the model with the inputs present at the edge,
  // then compare every output after the edge
  task automatic tick();
    smp_t   cur;
    bit     r, c, ev, st;
    longint rr;
    cur = '{vin, longint'(a), longint'(b), int'(sh)};
    r = rst;
    c = clr;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      ev = 0;
      if (s2.v) begin
        ref_calc(s2.a, s2.b, s2.s, rr, st);
        m_res = rr;
        ev = st;
      end
      m_v = s2.v;
      m_sat = ev;
      m_sticky = ev | (m_sticky & ~c);
      if (cnt_en) begin
        if (c) m_cnt = ev ? 1 : 0;
        else if (ev && m_cnt < (longint'(1) << CB) - 1) m_cnt++;
      end
      s2 = s1;
      s1 = cur;
    end
    chk("valid_o", longint'(vout), longint'(m_v));
    chk("result_o", longint'(res), m_res);
    chk("sat_o", longint'(sat), longint'(m_sat));
    chk("sat_sticky_o", longint'(sticky), longint'(m_sticky));
    chk("sat_cnt_o", longint'(cnt), m_cnt);
  endtask

  task automatic put(bit v, longint x, longint y, int s);
    vin = v;
    a = IA'(x);
    b = IB'(y);
    sh = SB'(s);
  endtask

  vec_t tbl[$];

  initial begin
`ifdef MULT_SATCNT_EN
    cnt_en = 1'b1;
`else
    cnt_en = 1'b0;
`endif
    model_reset();
    tbl.push_back('{3, 1, 1, 2, 0});
    tbl.push_back('{-3, 1, 1, -1, 0});
    tbl.push_back('{-8192, -8192, 13, 8191, 1});
    tbl.push_back('{-8192, 8191, 0, -8192, 1});
    tbl.push_back('{100, -50, 31, 0, 0});
    tbl.push_back('{5, 1, 1, 3, 0});
    tbl.push_back('{-5, 1, 1, -2, 0});
    tbl.push_back('{8191, 8191, 12, 8191, 1});
    tbl.push_back('{-8192, 1, 0, -8192, 0});

    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_result", longint'(res), 0);
    chk("rst_valid", longint'(vout), 0);
    rst = 1'b0;

    // fixed vectors, each alone through the pipe
    foreach (tbl[i]) begin
      put(1, tbl[i].a, tbl[i].b, tbl[i].s);
      tick();
      put(0, 0, 0, 0);
      tick();
      tick();
      chk("tbl_valid", longint'(vout), 1);
      chk("tbl_result", longint'(res), tbl[i].r);
      chk("tbl_sat", longint'(sat), longint'(tbl[i].sat));
      tick();
      chk("tbl_hold_v", longint'(vout), 0);
      chk("tbl_hold_r", longint'(res), tbl[i].r);
    end

    // back-to-back stream, shift alternating 0 / 4
    for (int i = 0; i < 8; i++) begin
      put(1, $signed(IA'($urandom)) >>> 4, $signed(IB'($urandom)) >>> 6,
          (i % 2) * 4);
      tick();
    end
    put(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();

    // saturation coinciding with clear: set wins
    put(1, -8192, -8192, 13);
    tick();
    put(0, 0, 0, 0);
    tick();
    clr = 1'b1;
    tick();
    chk("clr_coin_sat", longint'(sat), 1);
    chk("clr_coin_sticky", longint'(sticky), 1);
    if (cnt_en) chk("clr_coin_cnt", longint'(cnt), 1);
    tick();
    clr = 1'b0;
    chk("clr_sticky", longint'(sticky), 0);
    chk("clr_cnt", longint'(cnt), 0);

    // reset with 3 samples in flight
    for (int i = 0; i < 3; i++) begin
      put(1, -8192, -8192, 13);
      tick();
    end
    put(0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_fl_valid", longint'(vout), 0);
    chk("rst_fl_result", longint'(res), 0);
    chk("rst_fl_sticky", longint'(sticky), 0);
    for (int i = 0; i < 4; i++) tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      put($urandom_range(0, 3) != 0, $signed(IA'($urandom)),
          $signed(IB'($urandom)), $urandom_range(0, 31));
      clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    put(0, 0, 0, 0);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // counter saturates at all-ones
    if (cnt_en) begin
      clr = 1'b1;
      tick();
      clr = 1'b0;
      put(1, -8192, -8192, 13);
      for (int i = 0; i < (1 << CB) + 3; i++) tick();
      put(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) tick();
      chk("cnt_stuck", longint'(cnt), (longint'(1) << CB) - 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
